psram_writer: RTL
=================

# psram_writer

Write-side controller for the board's asynchronous cellular PSRAM. The display path only ever reads that memory. This block takes 16-bit words with byte enables over a valid/ready handshake and drives the PSRAM control, address and data pins through one timed asynchronous write cycle per word. It is used to load background and sprite images into PSRAM at start-up. It shares the MemAdr/MemDB pins with the display reader through an external arbiter.

## Interface
- SETUP_CYCLES, 1, clocks with address/data/ce_L valid before we_L falls (≥1)
- WE_CYCLES, 3, clocks we_L held low (≥1; 3×20 ns ≥ tWP 55 ns at 50 MHz)
- HOLD_CYCLES, 1, clocks address/data held after we_L rises (≥1)
- clk  input  1  system clock, 50 MHz; all logic on rising edge
- rst  input  1  reset; one clock, synchronous, active-low
- wr_valid  input  1  request present
- wr_ready  output  1  block can accept a request this cycle
- wr_addr  input  26  word address
- wr_data  input  16  write data
- wr_be  input  2  byte enables: [0] selects low byte (lb_L), [1] selects high byte (ub_L)
- MemAdr  output  26  PSRAM address
- MemDB_out  output  16  data to the pad tristate
- MemDB_oe  output  1  1 = drive MemDB_out onto the bus
- ce_L, we_L, oe_L, lb_L, ub_L  output  1 each  PSRAM strobes, active-low
- busy  output  1  write cycle in progress
- wr_count  output  16  number of completed non-empty writes, wraps

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD. One down-counter, wide enough for max(SETUP, WE, HOLD).
- IDLE: wr_ready=1.
  - On wr_valid & wr_ready, latch wr_addr, wr_data and wr_be.
  - If wr_be≠0, go to SETUP with counter=SETUP_CYCLES-1.
  - If wr_be=0, the request is accepted and dropped: no bus activity, no count, stay in IDLE.
- SETUP:
  - ce_L=0, we_L=1, MemDB_oe=1.
  - lb_L=~be[0], ub_L=~be[1].
  - MemAdr and MemDB_out take the latched values.
  - When the counter reaches 0, go to PULSE with counter=WE_CYCLES-1.
- PULSE: as SETUP, but we_L=0. When the counter reaches 0, go to HOLD with counter=HOLD_CYCLES-1.
- HOLD:
  - we_L=1, ce_L=0; address, data and MemDB_oe unchanged.
  - When the counter reaches 0, go to IDLE and increment wr_count (16-bit wrap, 0xFFFF→0x0000).
- Outside a write cycle:
  - oe_L=1 always; this block never reads.
  - ce_L=lb_L=ub_L=we_L=1, MemDB_oe=0.
  - MemAdr and MemDB_out keep their last values.
- busy=1 in SETUP, PULSE and HOLD.
- wr_ready=0 outside IDLE. A request presented then must be held by the source until accepted.
- Reset:
  - rst low at a clock edge forces IDLE from any state, including mid-PULSE. The in-flight write is abandoned.
  - All outputs take their reset values on that edge.
  - wr_ready is forced 0 while rst is low.
- Reset values: wr_ready=0, busy=0, ce_L=we_L=oe_L=lb_L=ub_L=1, MemDB_oe=0, MemAdr=0, MemDB_out=0, wr_count=0.

## Timing
- All outputs are registered; no combinational path from inputs to pins.
- Acceptance edge N: SETUP outputs appear after edge N+1.
- we_L is low for exactly WE_CYCLES clocks, beginning SETUP_CYCLES clocks after ce_L falls.
- ce_L returns high, and busy falls, after HOLD_CYCLES more clocks.
- Cycle length:
  - Non-empty write: 1+SETUP_CYCLES+WE_CYCLES+HOLD_CYCLES clocks from acceptance to the next acceptance. Default: 6 clocks, 120 ns (≥ tWC 70 ns).
  - wr_be=0 request: 1 clock.
- wr_count updates on the edge that leaves HOLD, in the same cycle busy falls.
- Back-to-back writes: ce_L is high for at least 1 clock between cycles. MemDB_oe drops for that idle clock.

## Test plan
- Reset then single write (addr 0x0000123, data 0xA5C3, be=11): exactly one we_L low pulse of 3 clocks. During it MemAdr=0x0000123, MemDB_out=0xA5C3, lb_L=ub_L=0, MemDB_oe=1. Afterwards wr_count=1 and oe_L stays 1 throughout.
- Byte writes: be=01 gives lb_L=0, ub_L=1; be=10 gives the reverse. be=00 is accepted in 1 clock with strobes idle and wr_count unchanged.
- wr_valid held high for 4 writes: wr_ready is high only in IDLE, one acceptance every 6 clocks, ce_L high 1 clock between cycles, wr_count=4.
- Reset asserted in the 2nd PULSE clock: on the next edge we_L=ce_L=1, MemDB_oe=0, wr_count=0. After release, a new write completes normally.
- Preset 65535 writes, then one more: wr_count wraps to 0x0000.
- Parameters SETUP=2, WE=5, HOLD=3: pulse widths match exactly (ce_L low 10 clocks, we_L low 5 clocks starting 2 clocks after ce_L falls).

Source files
------------

// File: rtl/psram_writer_if.sv
// Write-request handshake into the PSRAM writer: one 16-bit word with byte
// enables per valid/ready transfer.
interface psram_writer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [25:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;

  modport master (output wr_valid, wr_addr, wr_data, wr_be, input  wr_ready);
  modport slave  (input  wr_valid, wr_addr, wr_data, wr_be, output wr_ready);
endinterface

// File: rtl/psram_writer.sv
// Timed asynchronous write cycles into cellular PSRAM, one word per request.
// All pins are registered; strobe outputs trail the state register by one clock.
module psram_writer #(
  parameter int          SETUP_CYCLES  = 1,
  parameter int          WE_CYCLES     = 3,
  parameter int          HOLD_CYCLES   = 1,
  // wr_count value after reset; 0 in normal use, nonzero only to exercise wrap
  parameter logic [15:0] WR_COUNT_INIT = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  psram_writer_if.slave      wr,
  output logic [25:0]        MemAdr,
  output logic [15:0]        MemDB_out,
  output logic               MemDB_oe,
  output logic               ce_L,
  output logic               we_L,
  output logic               oe_L,
  output logic               lb_L,
  output logic               ub_L,
  output logic               busy,
  output logic [15:0]        wr_count
);

  localparam int MAX_SW = (SETUP_CYCLES > WE_CYCLES) ? SETUP_CYCLES : WE_CYCLES;
  localparam int MAXC   = (MAX_SW > HOLD_CYCLES) ? MAX_SW : HOLD_CYCLES;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [25:0]   lat_addr;
  logic [15:0]   lat_data;
  logic [1:0]    lat_be;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_addr    <= '0;
      lat_data    <= '0;
      lat_be      <= '0;
      wr.wr_ready <= 1'b0;
      busy        <= 1'b0;
      ce_L        <= 1'b1;
      we_L        <= 1'b1;
      oe_L        <= 1'b1;
      lb_L        <= 1'b1;
      ub_L        <= 1'b1;
      MemDB_oe    <= 1'b0;
      MemAdr      <= '0;
      MemDB_out   <= '0;
      wr_count    <= WR_COUNT_INIT;
    end else begin
      oe_L <= 1'b1;
      case (state)
        IDLE: begin
          ce_L        <= 1'b1;
          we_L        <= 1'b1;
          lb_L        <= 1'b1;
          ub_L        <= 1'b1;
          MemDB_oe    <= 1'b0;
          busy        <= 1'b0;
          wr.wr_ready <= 1'b1;
          // busy still high here means HOLD just finished: the write completed
          if (busy) wr_count <= wr_count + 16'd1;
          if (wr.wr_valid && wr.wr_ready) begin
            lat_addr <= wr.wr_addr;
            lat_data <= wr.wr_data;
            lat_be   <= wr.wr_be;
            if (wr.wr_be != 2'b00) begin
              state       <= SETUP;
              cnt         <= CW'(SETUP_CYCLES - 1);
              wr.wr_ready <= 1'b0;
            end
          end
        end
        default: begin
          ce_L        <= 1'b0;
          we_L        <= (state != PULSE);
          lb_L        <= ~lat_be[0];
          ub_L        <= ~lat_be[1];
          MemDB_oe    <= 1'b1;
          MemAdr      <= lat_addr;
          MemDB_out   <= lat_data;
          busy        <= 1'b1;
          // open the handshake one clock early so acceptance lands on the edge ce_L rises
          wr.wr_ready <= (state == HOLD) && (cnt == '0);
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            case (state)
              SETUP: begin state <= PULSE; cnt <= CW'(WE_CYCLES - 1);   end
              PULSE: begin state <= HOLD;  cnt <= CW'(HOLD_CYCLES - 1); end
              default:     state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
